// File: rtl/snr_monitor_pkg.sv
// Shared types and default constants for the SNR level monitor.
// Holds the level FSM state encoding and the counter sizing helper.
package snr_monitor_pkg;

  localparam int unsigned DEF_SNR_WIDTH      = 8;
  localparam int unsigned DEF_HI_DB          = 30;
  localparam int unsigned DEF_LO_DB          = 20;
  localparam int unsigned DEF_HOLD_SAMPLES   = 4800;
  localparam int unsigned DEF_WARMUP_SAMPLES = 4096;
  localparam int unsigned DEF_BAR_STEP       = 8;
  localparam int unsigned DEF_PEAK_DECAY     = 2400;
  localparam int unsigned BAR_SEGMENTS       = 8;
  localparam int unsigned STATE_W            = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_WARMUP     = 3'd0,
    ST_QUIET      = 3'd1,
    ST_PEND_LOUD  = 3'd2,
    ST_LOUD       = 3'd3,
    ST_PEND_QUIET = 3'd4
  } level_state_e;

  // Counter width able to hold 0..n inclusive, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/snr_level_monitor_if.sv
// Valid/ready sample stream from the upstream SNR estimator.
interface snr_level_monitor_if #(
  parameter int unsigned SNR_WIDTH = snr_monitor_pkg::DEF_SNR_WIDTH
);

  logic [SNR_WIDTH-1:0] snr_db;
  logic                 snr_valid;
  logic                 snr_ready;

  modport master (output snr_db, output snr_valid, input  snr_ready);
  modport slave  (input  snr_db, input  snr_valid, output snr_ready);

endinterface

// File: rtl/snr_level_monitor_peak_hold_decay.sv
// Peak tracker: loads on a new maximum, otherwise decays 1 dB every
// PEAK_DECAY accepted samples, saturating at zero.
module peak_hold_decay
  import snr_monitor_pkg::*;
#(
  parameter int unsigned SNR_WIDTH  = DEF_SNR_WIDTH,
  parameter int unsigned PEAK_DECAY = DEF_PEAK_DECAY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 accept,
  input  logic [SNR_WIDTH-1:0] sample,
  output logic [SNR_WIDTH-1:0] peak
);

  localparam int unsigned DEC_W = cnt_width(PEAK_DECAY);

  logic [DEC_W-1:0] dec_q;
  logic [DEC_W-1:0] dec_inc;

  assign dec_inc = dec_q + DEC_W'(1);

  // A new peak takes priority over a coincident decay tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak  <= '0;
      dec_q <= '0;
    end else if (accept) begin
      if (sample > peak) begin
        peak  <= sample;
        dec_q <= '0;
      end else if (dec_inc >= DEC_W'(PEAK_DECAY)) begin
        dec_q <= '0;
        if (peak != '0) begin
          peak <= peak - SNR_WIDTH'(1);
        end
      end else begin
        dec_q <= dec_inc;
      end
    end
  end

endmodule

// File: rtl/snr_level_monitor.sv
// SNR level monitor: warm-up, hysteretic loud/quiet FSM with hold counts,
// thermometer bar of the current sample and a decaying peak readout.
module snr_level_monitor
  import snr_monitor_pkg::*;
#(
  parameter int unsigned SNR_WIDTH      = DEF_SNR_WIDTH,
  parameter int unsigned HI_DB          = DEF_HI_DB,
  parameter int unsigned LO_DB          = DEF_LO_DB,
  parameter int unsigned HOLD_SAMPLES   = DEF_HOLD_SAMPLES,
  parameter int unsigned WARMUP_SAMPLES = DEF_WARMUP_SAMPLES,
  parameter int unsigned BAR_STEP       = DEF_BAR_STEP,
  parameter int unsigned PEAK_DECAY     = DEF_PEAK_DECAY
) (
  input  logic                        clk,
  input  logic                        reset,
  snr_level_monitor_if.slave          snr,
  output logic [STATE_W-1:0]          level_state,
  output logic                        alarm,
  output logic                        alarm_rise,
  output logic [BAR_SEGMENTS-1:0]     bar_leds,
  output logic [SNR_WIDTH-1:0]        peak_db
);

  localparam int unsigned BW     = SNR_WIDTH + 4;
  localparam int unsigned HOLD_W = cnt_width(HOLD_SAMPLES);
  localparam int unsigned WARM_W = cnt_width(WARMUP_SAMPLES);
  localparam bit          HOLD_ONE = (HOLD_SAMPLES <= 1);

  level_state_e              state_q, state_d;
  logic [HOLD_W-1:0]         hold_q, hold_d, hold_inc;
  logic [WARM_W-1:0]         warm_q, warm_d, warm_inc;
  logic [SNR_WIDTH-1:0]      sample;
  logic [BW-1:0]             sample_ext;
  logic                      accept;
  logic                      is_loud;
  logic                      is_quiet;
  logic                      alarm_d;
  logic                      rise_d;
  logic [BAR_SEGMENTS-1:0]   bar_d;

  assign snr.snr_ready = ~reset;
  assign accept        = snr.snr_valid & ~reset;
  assign sample        = snr.snr_db;
  assign sample_ext    = BW'(sample);
  assign is_loud       = sample_ext >= BW'(HI_DB);
  assign is_quiet      = sample_ext <  BW'(LO_DB);
  assign hold_inc      = hold_q + HOLD_W'(1);
  assign warm_inc      = warm_q + WARM_W'(1);
  assign level_state   = state_q;

  // Next-state and counter updates; only an accepted sample advances anything.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    warm_d  = warm_q;
    if (accept) begin
      unique case (state_q)
        ST_WARMUP: begin
          warm_d = warm_inc;
          if (warm_inc >= WARM_W'(WARMUP_SAMPLES)) begin
            state_d = ST_QUIET;
          end
        end
        ST_QUIET: begin
          if (is_loud) begin
            state_d = HOLD_ONE ? ST_LOUD : ST_PEND_LOUD;
            hold_d  = HOLD_ONE ? '0 : HOLD_W'(1);
          end
        end
        ST_PEND_LOUD: begin
          if (!is_loud) begin
            state_d = ST_QUIET;
            hold_d  = '0;
          end else if (hold_inc >= HOLD_W'(HOLD_SAMPLES)) begin
            state_d = ST_LOUD;
            hold_d  = '0;
          end else begin
            hold_d  = hold_inc;
          end
        end
        ST_LOUD: begin
          if (is_quiet) begin
            state_d = HOLD_ONE ? ST_QUIET : ST_PEND_QUIET;
            hold_d  = HOLD_ONE ? '0 : HOLD_W'(1);
          end
        end
        ST_PEND_QUIET: begin
          if (!is_quiet) begin
            state_d = ST_LOUD;
            hold_d  = '0;
          end else if (hold_inc >= HOLD_W'(HOLD_SAMPLES)) begin
            state_d = ST_QUIET;
            hold_d  = '0;
          end else begin
            hold_d  = hold_inc;
          end
        end
        default: begin
          state_d = ST_WARMUP;
          hold_d  = '0;
          warm_d  = '0;
        end
      endcase
    end
  end

  // Output values implied by the next state and the current sample.
  always_comb begin
    alarm_d = (state_d == ST_LOUD) || (state_d == ST_PEND_QUIET);
    rise_d  = (state_d == ST_LOUD) && (state_q != ST_LOUD);
    bar_d   = '0;
    for (int unsigned i = 0; i < BAR_SEGMENTS; i++) begin
      bar_d[i] = sample_ext >= BW'((i + 1) * BAR_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_WARMUP;
      hold_q     <= '0;
      warm_q     <= '0;
      alarm      <= 1'b0;
      alarm_rise <= 1'b0;
      bar_leds   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      warm_q  <= warm_d;
      if (accept) begin
        alarm      <= alarm_d;
        alarm_rise <= rise_d;
        bar_leds   <= bar_d;
      end else begin
        alarm_rise <= 1'b0;
      end
    end
  end

  peak_hold_decay #(
    .SNR_WIDTH  (SNR_WIDTH),
    .PEAK_DECAY (PEAK_DECAY)
  ) u_peak (
    .clk    (clk),
    .reset  (reset),
    .accept (accept),
    .sample (sample),
    .peak   (peak_db)
  );

endmodule

// File: tb/tb_snr_level_monitor.sv
// Bench for snr_level_monitor: directed scenarios then randomized traffic,
// all compared against a sample-level behavioural model.
module tb_snr_level_monitor;
  import snr_monitor_pkg::*;

  localparam int unsigned SW     = 8;
  localparam int unsigned HI     = 30;
  localparam int unsigned LO     = 20;
  localparam int unsigned HOLD   = 3;
  localparam int unsigned WARM   = 4;
  localparam int unsigned STEP   = 8;
  localparam int unsigned DECAY  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    level_state;
  logic          alarm;
  logic          alarm_rise;
  logic [7:0]    bar_leds;
  logic [SW-1:0] peak_db;

  always #5 clk = ~clk;

  snr_level_monitor_if #(.SNR_WIDTH(SW)) snr_bus ();

  snr_level_monitor #(
    .SNR_WIDTH      (SW),
    .HI_DB          (HI),
    .LO_DB          (LO),
    .HOLD_SAMPLES   (HOLD),
    .WARMUP_SAMPLES (WARM),
    .BAR_STEP       (STEP),
    .PEAK_DECAY     (DECAY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .snr         (snr_bus),
    .level_state (level_state),
    .alarm       (alarm),
    .alarm_rise  (alarm_rise),
    .bar_leds    (bar_leds),
    .peak_db     (peak_db)
  );

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  // Reference model state, kept at the level of "samples seen" rather than registers.
  level_state_e m_state;
  int           m_warm, m_run, m_peak, m_since_peak, m_bar;
  bit           m_alarm, m_rise;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s/%s observed %0d expected %0d", phase, tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = ST_WARMUP; m_warm = 0; m_run = 0;
    m_peak = 0; m_since_peak = 0; m_bar = 0;
    m_alarm = 0; m_rise = 0;
  endfunction

  function automatic void model_accept(input int d);
    bit was_loud = (m_state == ST_LOUD);
    m_bar = 0;
    for (int i = 0; i < 8; i++) if (d >= (i + 1) * int'(STEP)) m_bar |= (1 << i);
    if (d > m_peak) begin
      m_peak = d; m_since_peak = 0;
    end else begin
      m_since_peak++;
      if (m_since_peak == int'(DECAY)) begin
        m_since_peak = 0;
        if (m_peak > 0) m_peak--;
      end
    end
    case (m_state)
      ST_WARMUP: begin
        m_warm++;
        if (m_warm == int'(WARM)) m_state = ST_QUIET;
      end
      ST_QUIET, ST_PEND_LOUD: begin
        if (d >= int'(HI)) begin
          m_run++;
          if (m_run == int'(HOLD)) begin m_state = ST_LOUD; m_run = 0; end
          else m_state = ST_PEND_LOUD;
        end else begin
          m_state = ST_QUIET; m_run = 0;
        end
      end
      default: begin
        if (d < int'(LO)) begin
          m_run++;
          if (m_run == int'(HOLD)) begin m_state = ST_QUIET; m_run = 0; end
          else m_state = ST_PEND_QUIET;
        end else begin
          m_state = ST_LOUD; m_run = 0;
        end
      end
    endcase
    m_alarm = (m_state == ST_LOUD) || (m_state == ST_PEND_QUIET);
    m_rise  = (m_state == ST_LOUD) && !was_loud;
  endfunction

  // One clock: drive, let the edge happen, advance the model, sample 1 ns later.
  task automatic step(input bit rst, input bit v, input int d);
    reset             = rst;
    snr_bus.snr_valid = v;
    snr_bus.snr_db    = SW'(d);
    @(posedge clk);
    if (rst)    model_reset();
    else if (v) model_accept(d);
    else        m_rise = 0;
    #1;
    chk("level_state", level_state, m_state);
    chk("alarm",       alarm,       m_alarm);
    chk("alarm_rise",  alarm_rise,  m_rise);
    chk("bar_leds",    bar_leds,    m_bar);
    chk("peak_db",     peak_db,     m_peak);
    chk("snr_ready",   snr_bus.snr_ready, !rst);
  endtask

  initial begin
    int region;
    bit r, v;
    int d;

    reset = 1'b1; snr_bus.snr_valid = 1'b0; snr_bus.snr_db = '0;
    model_reset();

    phase = "reset";
    step(1, 1, 77);
    step(1, 1, 77);
    chk("rst_state", level_state, ST_WARMUP);
    chk("rst_peak",  peak_db, 0);
    chk("rst_bar",   bar_leds, 0);

    phase = "warmup";
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 40);
      chk("warm_state", level_state, (i < 3) ? ST_WARMUP : ST_QUIET);
    end
    chk("warm_bar",   bar_leds, 8'h1F);
    chk("warm_alarm", alarm, 0);
    step(0, 0, 0);

    phase = "to_loud";
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 30);
      chk("rise_pulse", alarm_rise, (i == 2) ? 1 : 0);
    end
    chk("loud_state", level_state, ST_LOUD);
    step(0, 0, 0);
    chk("rise_single", alarm_rise, 0);
    chk("loud_hold",   level_state, ST_LOUD);

    phase = "to_quiet";
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 20);
      chk("lo_edge_state", level_state, ST_LOUD);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 19);
      chk("pq_state", level_state, (i < 2) ? ST_PEND_QUIET : ST_QUIET);
      chk("pq_alarm", alarm, (i < 2) ? 1 : 0);
    end

    phase = "glitch";
    step(0, 1, 35); chk("g_alarm", alarm, 0);
    step(0, 1, 35); chk("g_alarm", alarm, 0);
    step(0, 1, 29); chk("g_state", level_state, ST_QUIET); chk("g_alarm", alarm, 0);
    step(0, 1, 35); chk("g_state", level_state, ST_PEND_LOUD); chk("g_alarm", alarm, 0);
    step(0, 1, 0);

    phase = "peak";
    step(0, 1, 50);
    chk("peak_load", peak_db, 50);
    chk("peak_bar",  bar_leds, 8'h3F);
    step(0, 1, 0); chk("peak_z1", peak_db, 50);
    step(0, 1, 0); chk("peak_z2", peak_db, 49);
    step(0, 1, 0); chk("peak_z3", peak_db, 49);
    step(0, 1, 0); chk("peak_z4", peak_db, 48);
    chk("peak_bar0", bar_leds, 8'h00);

    phase = "mid_reset";
    step(0, 1, 35);
    chk("pend_state", level_state, ST_PEND_LOUD);
    step(1, 1, 35);
    chk("mr_state", level_state, ST_WARMUP);
    chk("mr_alarm", alarm, 0);
    chk("mr_peak",  peak_db, 0);
    chk("mr_bar",   bar_leds, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 35);
      chk("mr_warm", level_state, (i < 3) ? ST_WARMUP : ST_QUIET);
    end

    phase = "random";
    region = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 29) == 0) region = int'($urandom_range(0, 2));
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 3) != 0);
      case (region)
        0:       d = int'($urandom_range(0, 25));
        1:       d = int'($urandom_range(17, 33));
        default: d = int'($urandom_range(28, 255));
      endcase
      step(r, v, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snr_level_monitor.md
SNR_LEVEL_MONITOR -- requirements
Module: snr_level_monitor

Interface
REQ-001 The block SHALL have parameter SNR_WIDTH, default 8, which sets the width of the SNR value in dB.
REQ-002 The block SHALL have parameter HI_DB, default 30, the loud threshold (inclusive, >=).
REQ-003 The block SHALL have parameter LO_DB, default 20, the quiet threshold (exclusive, <); HI_DB > LO_DB is required.
REQ-004 The block SHALL have parameter HOLD_SAMPLES, default 4800, the number of consecutive qualifying samples needed to change state.
REQ-005 The block SHALL have parameter WARMUP_SAMPLES, default 4096, the number of samples ignored by the FSM after reset while the upstream averages settle.
REQ-006 The block SHALL have parameter BAR_STEP, default 8, the dB per bar segment.
REQ-007 The block SHALL have parameter PEAK_DECAY, default 2400, the number of accepted samples per 1 dB of peak decay.
REQ-008 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-009 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 The block SHALL have port snr_db, input, SNR_WIDTH bits: unsigned SNR from the upstream SNR estimator.
REQ-011 The block SHALL have port snr_valid, input, 1 bit: snr_db is valid.
REQ-012 The block SHALL have port snr_ready, output, 1 bit: the block can accept a sample.
REQ-013 The block SHALL have port level_state, output, 3 bits: the current FSM state encoding.
REQ-014 The block SHALL have port alarm, output, 1 bit: the sound is loud.
REQ-015 The block SHALL have port alarm_rise, output, 1 bit: a one-cycle pulse on entry to LOUD.
REQ-016 The block SHALL have port bar_leds, output, 8 bits: a thermometer bar of the current SNR.
REQ-017 The block SHALL have port peak_db, output, SNR_WIDTH bits: the decaying peak SNR.

Function
REQ-018 A sample SHALL be accepted on any clock where snr_valid && snr_ready; snr_ready SHALL be 0 while reset is high and 1 otherwise.
REQ-019 All outputs SHALL be registered and SHALL reflect an accepted sample exactly one clock after acceptance; outputs SHALL hold when no sample is accepted.
REQ-020 The FSM SHALL have states WARMUP, QUIET, PEND_LOUD, LOUD and PEND_QUIET.
REQ-021 In WARMUP, the FSM SHALL count accepted samples and SHALL move to QUIET on the WARMUP_SAMPLES-th sample, ignoring snr_db.
REQ-022 In QUIET, a sample with snr_db >= HI_DB SHALL move the FSM to PEND_LOUD with the hold count set to 1.
REQ-023 In PEND_LOUD, a sample with snr_db >= HI_DB SHALL increment the hold count; on reaching HOLD_SAMPLES the FSM SHALL enter LOUD, and a sample below HI_DB SHALL return the FSM to QUIET with the count cleared.
REQ-024 LOUD to PEND_QUIET to QUIET SHALL follow the same rules as REQ-022/REQ-023, using snr_db < LO_DB.
REQ-025 A value of snr_db == LO_DB SHALL NOT qualify as quiet, and a value of snr_db == HI_DB SHALL qualify as loud.
REQ-026 alarm SHALL be 1 in LOUD and PEND_QUIET, and 0 otherwise.
REQ-027 alarm_rise SHALL be high for exactly one clock, coincident with the first cycle level_state shows LOUD.
REQ-028 bar_leds[i] SHALL be 1 iff snr_db >= (i+1)*BAR_STEP, for i = 0..7; the comparison SHALL be performed at SNR_WIDTH+4 bits so there is no overflow, and bar_leds SHALL update during WARMUP as well.
REQ-029 Peak behaviour on each accepted sample:
- If snr_db > peak_db, peak_db SHALL load snr_db and the decay counter SHALL clear.
- Otherwise the decay counter SHALL increment; at PEAK_DECAY it SHALL wrap to 0 and peak_db SHALL decrement by 1, saturating at 0.
- If a new peak and a decay tick coincide, the new peak SHALL win.
REQ-030 The hold, warmup and decay counters SHALL be sized with $clog2(param+1) and SHALL never wrap past their terminal value.

Reset
REQ-031 While reset is high, the following values SHALL apply:
- state = WARMUP
- all counters = 0
- alarm = 0
- alarm_rise = 0
- bar_leds = 0
- peak_db = 0
- level_state = WARMUP encoding
REQ-032 Reset asserted mid-operation, including in LOUD or a pending state, SHALL abandon the operation immediately; the next accepted sample after release SHALL count as warmup sample 1.

Structure
REQ-033 The state enum, its 3-bit encoding and default parameter constants SHALL reside in the shared package snr_monitor_pkg.
REQ-034 Peak tracking and decay SHALL be implemented as the sub-module peak_hold_decay, instantiated once.

Verification (all scenarios use WARMUP_SAMPLES=4, HOLD_SAMPLES=3, HI_DB=30, LO_DB=20, BAR_STEP=8, PEAK_DECAY=2)
REQ-035 Verification SHALL apply reset followed by 4 samples of 40 -> level_state SHALL be WARMUP for the first 3 samples and QUIET after the 4th, with alarm=0 and bar_leds=8'h1F.
REQ-036 Verification SHALL apply, from QUIET, the samples 30,30,30 -> LOUD one clock after the 3rd sample, with a single alarm_rise pulse.
REQ-037 Verification SHALL apply, from QUIET, the samples 35,35,29,35 -> the FSM SHALL return to QUIET after 29, and alarm SHALL never assert.
REQ-038 Verification SHALL apply, from LOUD, the samples 20,20,20 and then 19,19,19 -> the FSM SHALL stay LOUD through the 20s, then reach QUIET after the third 19, with alarm remaining 1 through PEND_QUIET.
REQ-039 Verification SHALL apply the samples 50,0,0,0,0 -> peak_db SHALL be 50, then 49 after the 2nd zero and 48 after the 4th; bar_leds SHALL be 8'h3F and then 8'h00.
REQ-040 Verification SHALL assert reset for 1 clock while in PEND_LOUD with snr_valid held high -> all outputs SHALL be at their reset values and the warmup count SHALL restart.
